mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port memory bus between the pipeline's fetch port (IF) and data port (MEM stage).
//  Data accesses win by default; a starvation counter forces a fetch grant after STARVE_MAX consecutive data grants.
//  One transaction is outstanding at a time; m_ack closes it, and a watchdog closes it if m_ack never arrives.
//  The pipeline stalls on ~i_ready / ~d_ready while a request is pending.
// PARAMETERS
//  ADDR_W      32   address width, both ports and the memory bus
//  DATA_W      32   data width
//  STARVE_MAX  4    consecutive data grants (fetch pending) before a fetch grant is forced; >=1
//  TIMEOUT     255  cycles in a grant state without m_ack before abort; >=2
// PORTS
//  clk      in   1       clock
//  reset    in   1       synchronous, active-high reset
//  i_req    in   1       fetch request; requester holds it and i_addr until i_ready
//  i_addr   in   ADDR_W  fetch address (PC)
//  i_rdata  out  DATA_W  fetched instruction; valid while i_ready=1
//  i_ready  out  1       one-cycle pulse: fetch complete
//  d_req    in   1       data request (MemRead | mem_w); payload held until d_ready
//  d_we     in   1       1=store, 0=load
//  d_addr   in   ADDR_W  data address (ALU result)
//  d_wdata  in   DATA_W  store data
//  d_type   in   3       DMType byte/half/word code, passed through unchanged
//  d_rdata  out  DATA_W  load data; valid while d_ready=1
//  d_ready  out  1       one-cycle pulse: data access complete
//  m_req    out  1       memory request, held until m_ack or abort
//  m_we     out  1       memory write enable
//  m_addr   out  ADDR_W  memory address
//  m_wdata  out  DATA_W  memory write data
//  m_type   out  3       access type (fetch grants drive word code)
//  m_rdata  in   DATA_W  memory read data; sampled when m_ack=1
//  m_ack    in   1       memory completion, one cycle
//  err      out  1       sticky timeout flag; cleared only by reset
// BEHAVIOUR
//  - Reset: state IDLE. All outputs 0. starve_cnt=0, wd_cnt=0. An m_ack arriving in IDLE is ignored.
//  - FSM states: IDLE, GNT_I, GNT_D. All m_* outputs are registered and stay stable for the whole grant.
//  - IDLE, candidate set:
//      - A port whose x_ready is 1 in this cycle is masked out, so a just-served request is not re-granted.
//      - Grant I if i_req & (~d_req | starve_cnt==STARVE_MAX); otherwise grant D if d_req; otherwise stay in IDLE.
//  - Latching on grant:
//      - The grant latches the payload into m_*. m_req=1 from the next cycle.
//      - Fetch grant: m_we=0 and m_type=word.
//  - starve_cnt update:
//      - Data grant with i_req high: starve_cnt+1, saturating at STARVE_MAX.
//      - Fetch grant, or data grant with i_req low: starve_cnt cleared to 0.
//  - GNT_x with m_ack=1:
//      - Next cycle: x_rdata<=m_rdata (stores leave d_rdata unchanged), x_ready=1 for 1 cycle, m_req=0, state IDLE.
//  - Latency: request seen in IDLE at cycle 0, m_req at cycle 1, m_ack at cycle k>=1, x_ready at k+1.
//    Minimum is 2 cycles. There is always >=1 m_req=0 cycle between transactions.
//  - Watchdog:
//      - wd_cnt clears on grant and increments each GNT cycle without m_ack.
//      - At wd_cnt==TIMEOUT: m_req=0, x_ready pulses with x_rdata=32'hDEADBEEF, err<=1, state IDLE.
//      - m_ack in the same cycle as the timeout wins: normal completion, err unchanged.
//  - Simultaneous i_req and d_req in IDLE resolve purely by the priority rule above.
//  - The other port's request stays pending, with its ready low, until its own grant.
//  - Dropping a request before its ready is illegal. The arbiter completes the transaction anyway.
//  - Reset during a grant: immediate return to IDLE, all outputs 0. An m_ack in flight is discarded.
// STRUCTURE
//  - Shared include mem_arb_def.v: ARB_IDLE/ARB_GNT_I/ARB_GNT_D state codes, the word DMType code, ARB_ABORT_DATA.
//  - Sub-module mem_arb_watchdog (wd_cnt, its clear/enable, timeout output). All other logic stays in this module.
// TESTING
//  - Lone fetch: i_req=1, i_addr=0x40, m_ack at cycle 3 with m_rdata=0x00500093
//      -> m_req high cycles 1-3; i_ready pulse at cycle 4 with i_rdata=0x00500093.
//  - Collision: i_req and d_req (load 0x1000) both rise at cycle 0, memory acks 1 cycle after m_req
//      -> D granted first, I granted next; i_ready exactly 1 cycle after d_ready+gap, never the same cycle.
//  - Starvation, STARVE_MAX=4: d_req held high over 6 back-to-back stores with i_req high
//      -> grant order D,D,D,D,I,D; starve_cnt reads 0 after the I grant.
//  - Store: d_we=1, d_addr=0x2004, d_wdata=0xCAFEF00D, d_type=byte
//      -> m_we=1 and m_type=byte for the whole grant; d_ready pulses once; d_rdata keeps its previous value.
//  - Timeout, TIMEOUT=8: data grant, m_ack never asserted
//      -> m_req drops after 8 cycles; d_ready pulses with 0xDEADBEEF; err=1 until reset. Late m_ack ignored.
//  - Reset mid-grant: reset at cycle 2 of GNT_I, m_ack at cycle 3
//      -> m_req=0 from cycle 3; i_ready is never pulsed; state IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GNT_I = 2'd1,
        ARB_GNT_D = 2'd2
    } arb_state_e;

    localparam int          DMT_W          = 3;
    localparam logic [2:0]  DMT_BYTE       = 3'b000;
    localparam logic [2:0]  DMT_HALF       = 3'b001;
    localparam logic [2:0]  DMT_WORD       = 3'b010;
    localparam logic [31:0] ARB_ABORT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch port, data port and memory bus of the arbiter in one bundle.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import mem_port_arbiter_pkg::*;

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DMT_W-1:0]  d_type;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;

    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DMT_W-1:0]  m_type;
    logic [DATA_W-1:0] m_rdata;
    logic              m_ack;

    logic              err;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_type, m_rdata, m_ack,
        output i_rdata, i_ready, d_rdata, d_ready, m_req, m_we, m_addr, m_wdata, m_type, err
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_type, m_rdata, m_ack,
        input  i_rdata, i_ready, d_rdata, d_ready, m_req, m_we, m_addr, m_wdata, m_type, err
    );

endinterface

// File: rtl/mem_arb_watchdog.sv
// Grant watchdog: counts silent grant cycles, flags the TIMEOUT-th one.
// Combinational timeout from registered count; no backpressure.
module mem_arb_watchdog
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic timeout
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (clr) begin
            wd_cnt_d = '0;
        end else if (en) begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end

    // Fires on the cycle whose increment would reach TIMEOUT; an m_ack that cycle masks en.
    assign timeout = en && (wd_cnt_q == WD_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between fetch and data ports; data wins unless fetch is starved.
// Request to ready >= 2 cycles, one outstanding access; requesters stall on ~x_ready.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.master bus
);
    localparam int SC_W = $clog2(STARVE_MAX + 1);

    arb_state_e        state_q, state_d;
    logic [SC_W-1:0]   starve_cnt_q, starve_cnt_d;
    logic              m_req_q, m_req_d;
    logic              m_we_q, m_we_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic [DMT_W-1:0]  m_type_q, m_type_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic              i_ready_q, i_ready_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              d_ready_q, d_ready_d;
    logic              err_q, err_d;

    logic              starved, grant_i, grant_d, in_gnt, timeout, done;
    logic [DATA_W-1:0] resp_data;

    // A port pulsing ready is masked, but the raw d_req still holds off a non-starved fetch.
    assign starved   = (starve_cnt_q == SC_W'(STARVE_MAX));
    assign grant_i   = (state_q == ARB_IDLE) && bus.i_req && !i_ready_q && (!bus.d_req || starved);
    assign grant_d   = (state_q == ARB_IDLE) && !grant_i && bus.d_req && !d_ready_q;
    assign in_gnt    = (state_q != ARB_IDLE);
    assign done      = in_gnt && (bus.m_ack || timeout);
    assign resp_data = bus.m_ack ? bus.m_rdata : DATA_W'(ARB_ABORT_DATA);

    mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (grant_i || grant_d),
        .en      (in_gnt && !bus.m_ack),
        .timeout (timeout)
    );

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        m_req_d      = m_req_q;
        m_we_d       = m_we_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        m_type_d     = m_type_q;
        i_rdata_d    = i_rdata_q;
        i_ready_d    = 1'b0;
        d_rdata_d    = d_rdata_q;
        d_ready_d    = 1'b0;
        err_d        = err_q;

        unique case (state_q)
            ARB_IDLE: begin
                if (grant_i) begin
                    state_d      = ARB_GNT_I;
                    starve_cnt_d = '0;
                    m_req_d      = 1'b1;
                    m_we_d       = 1'b0;
                    m_addr_d     = bus.i_addr;
                    m_wdata_d    = '0;
                    m_type_d     = DMT_WORD;
                end else if (grant_d) begin
                    state_d   = ARB_GNT_D;
                    m_req_d   = 1'b1;
                    m_we_d    = bus.d_we;
                    m_addr_d  = bus.d_addr;
                    m_wdata_d = bus.d_wdata;
                    m_type_d  = bus.d_type;
                    if (!bus.i_req) begin
                        starve_cnt_d = '0;
                    end else if (!starved) begin
                        starve_cnt_d = starve_cnt_q + SC_W'(1);
                    end
                end
            end
            ARB_GNT_I: begin
                if (done) begin
                    i_rdata_d = resp_data;
                    i_ready_d = 1'b1;
                end
            end
            ARB_GNT_D: begin
                if (done) begin
                    // Completed stores keep the last load result; aborts always report the marker.
                    if (!bus.m_ack || !m_we_q) begin
                        d_rdata_d = resp_data;
                    end
                    d_ready_d = 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        if (done) begin
            m_req_d = 1'b0;
            state_d = ARB_IDLE;
            if (!bus.m_ack) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            starve_cnt_q <= '0;
            m_req_q      <= 1'b0;
            m_we_q       <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            m_type_q     <= '0;
            i_rdata_q    <= '0;
            i_ready_q    <= 1'b0;
            d_rdata_q    <= '0;
            d_ready_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            m_req_q      <= m_req_d;
            m_we_q       <= m_we_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            m_type_q     <= m_type_d;
            i_rdata_q    <= i_rdata_d;
            i_ready_q    <= i_ready_d;
            d_rdata_q    <= d_rdata_d;
            d_ready_q    <= d_ready_d;
            err_q        <= err_d;
        end
    end

    assign bus.m_req   = m_req_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.m_type  = m_type_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.i_ready = i_ready_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.d_ready = d_ready_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit cmp_en      = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Transaction-level model: one open access record, a silent-cycle age and a starvation tally.
    logic        e_i_ready, e_d_ready, e_m_req, e_m_we, e_err;
    logic [31:0] e_i_rdata, e_d_rdata, e_m_addr, e_m_wdata;
    logic [2:0]  e_m_type;
    int          cur_port;
    int          cur_age;
    int          starve;
    int          glog[$];

    always @(posedge clk) begin
        bit          was_i, was_d;
        logic [31:0] resp;
        if (reset) begin
            cur_port = 0; cur_age = 0; starve = 0;
            e_i_ready = 0; e_d_ready = 0; e_m_req = 0; e_m_we = 0; e_err = 0;
            e_i_rdata = 0; e_d_rdata = 0; e_m_addr = 0; e_m_wdata = 0; e_m_type = 0;
        end else begin
            was_i = e_i_ready;
            was_d = e_d_ready;
            e_i_ready = 0;
            e_d_ready = 0;
            if (cur_port != 0) begin
                if (bus.m_ack || cur_age + 1 == TIMEOUT) begin
                    resp = bus.m_ack ? bus.m_rdata : 32'hDEADBEEF;
                    if (!bus.m_ack) e_err = 1;
                    if (cur_port == 1) begin
                        e_i_ready = 1;
                        e_i_rdata = resp;
                    end else begin
                        e_d_ready = 1;
                        if (!(bus.m_ack && e_m_we)) e_d_rdata = resp;
                    end
                    cur_port = 0;
                end else begin
                    cur_age++;
                end
            end else if (bus.i_req && !was_i && (!bus.d_req || starve == STARVE_MAX)) begin
                cur_port = 1; cur_age = 0; starve = 0;
                e_m_we = 0; e_m_addr = bus.i_addr; e_m_type = 3'b010;
                glog.push_back(0);
            end else if (bus.d_req && !was_d) begin
                cur_port = 2; cur_age = 0;
                starve = bus.i_req ? ((starve < STARVE_MAX) ? starve + 1 : STARVE_MAX) : 0;
                e_m_we = bus.d_we; e_m_addr = bus.d_addr; e_m_wdata = bus.d_wdata; e_m_type = bus.d_type;
                glog.push_back(1);
            end
            e_m_req = (cur_port != 0);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("i_ready", bus.i_ready, e_i_ready);
            check("d_ready", bus.d_ready, e_d_ready);
            check("m_req", bus.m_req, e_m_req);
            check("err", bus.err, e_err);
            check("i_rdata", bus.i_rdata, e_i_rdata);
            check("d_rdata", bus.d_rdata, e_d_rdata);
            if (e_m_req) begin
                check("m_we", bus.m_we, e_m_we);
                check("m_addr", bus.m_addr, e_m_addr);
                check("m_type", bus.m_type, e_m_type);
                if (e_m_we) check("m_wdata", bus.m_wdata, e_m_wdata);
            end
        end
    end

    // Memory responder: fixed latency (>=0) with address-tagged data, or random (<0) with stray acks.
    bit mem_busy = 1'b0;
    int mem_lat  = 0;

    task automatic mem_auto(input int fixed);
        bus.m_ack = 1'b0;
        if (bus.m_req) begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                if (fixed >= 0) mem_lat = fixed;
                else mem_lat = ($urandom_range(0, 9) == 0) ? TIMEOUT + 2 : int'($urandom_range(0, 3));
            end
            if (mem_lat == 0) begin
                bus.m_ack   = 1'b1;
                bus.m_rdata = (fixed >= 0) ? (32'hA5000000 ^ bus.m_addr) : $urandom;
                mem_busy    = 1'b0;
            end else begin
                mem_lat--;
            end
        end else begin
            mem_busy = 1'b0;
            if (fixed < 0 && $urandom_range(0, 15) == 0) begin
                bus.m_ack   = 1'b1;
                bus.m_rdata = $urandom;
            end
        end
    endtask

    task automatic drive_rand();
        if (bus.i_req && bus.i_ready) bus.i_req = 1'b0;
        if (!bus.i_req && $urandom_range(0, 2) == 0) begin
            bus.i_req  = 1'b1;
            bus.i_addr = $urandom & 32'hFFFF_FFFC;
        end
        if (bus.d_req && bus.d_ready) bus.d_req = 1'b0;
        if (!bus.d_req && $urandom_range(0, 1) == 0) begin
            bus.d_req   = 1'b1;
            bus.d_we    = 1'($urandom_range(0, 1));
            bus.d_addr  = $urandom;
            bus.d_wdata = $urandom;
            bus.d_type  = 3'($urandom_range(0, 7));
        end
        mem_auto(-1);
    endtask

    initial begin
        int          d_at, i_at, ngr, n_st, nrdy;
        bit          prev_mreq, i_done;
        logic [5:0]  dut_grants, mg;

        bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0;
        bus.d_wdata = 0; bus.d_type = 0; bus.m_rdata = 0; bus.m_ack = 0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        cmp_en = 1'b1;
        tick();
        check("rst_m_req", bus.m_req, 0);
        check("rst_i_ready", bus.i_ready, 0);
        check("rst_d_rdata", bus.d_rdata, 0);
        check("rst_err", bus.err, 0);
        reset = 1'b0;

        // Lone fetch, m_ack at cycle 3.
        bus.i_req = 1; bus.i_addr = 32'h40;
        tick();
        check("lf_mreq_c1", bus.m_req, 1);
        check("lf_maddr", bus.m_addr, 32'h40);
        check("lf_mwe", bus.m_we, 0);
        check("lf_mtype", bus.m_type, DMT_WORD);
        tick();
        check("lf_mreq_c2", bus.m_req, 1);
        tick();
        check("lf_mreq_c3", bus.m_req, 1);
        bus.m_ack = 1; bus.m_rdata = 32'h00500093;
        tick();
        check("lf_iready_c4", bus.i_ready, 1);
        check("lf_irdata", bus.i_rdata, 32'h00500093);
        check("lf_mreq_c4", bus.m_req, 0);
        bus.m_ack = 0; bus.i_req = 0;
        tick();
        check("lf_iready_c5", bus.i_ready, 0);

        // Collision: data load wins, fetch follows after the gap cycle.
        bus.i_req = 1; bus.i_addr = 32'h80;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h1000; bus.d_type = DMT_WORD;
        d_at = -1; i_at = -1;
        mem_auto(1);
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (t == 1) check("col_first_addr", bus.m_addr, 32'h1000);
            if (t == 4) check("col_second_addr", bus.m_addr, 32'h80);
            if (bus.d_ready) begin
                d_at = t; bus.d_req = 0;
                check("col_drdata", bus.d_rdata, 32'hA5001000);
            end
            if (bus.i_ready) begin
                i_at = t; bus.i_req = 0;
                check("col_irdata", bus.i_rdata, 32'hA5000080);
            end
            mem_auto(1);
        end
        check("col_d_ready_cycle", d_at, 3);
        check("col_i_ready_cycle", i_at, 6);

        // Starvation: six back-to-back stores with a fetch pending.
        bus.i_req = 1; bus.i_addr = 32'h100;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h3000; bus.d_wdata = $urandom; bus.d_type = DMT_WORD;
        glog.delete();
        dut_grants = 0; ngr = 0; n_st = 0; prev_mreq = 0; i_done = 0;
        mem_auto(0);
        for (int t = 1; t <= 80; t++) begin
            tick();
            if (bus.m_req && !prev_mreq) begin
                if (ngr < 6) dut_grants = {dut_grants[4:0], bus.m_we};
                ngr++;
                if (!bus.m_we) check("starve_cnt_after_i", dut.starve_cnt_q, 0);
            end
            prev_mreq = bus.m_req;
            if (bus.i_ready) begin bus.i_req = 0; i_done = 1; end
            if (bus.d_ready) begin
                n_st++;
                if (n_st < 6) begin
                    bus.d_addr  = 32'h3000 + 32'(4 * n_st);
                    bus.d_wdata = $urandom;
                end else begin
                    bus.d_req = 0;
                end
            end
            mem_auto(0);
        end
        mg = 0;
        for (int k = 0; k < 6 && k < glog.size(); k++) mg = {mg[4:0], (glog[k] != 0)};
        check("starve_order_dut", dut_grants, 6'b111101);
        check("starve_order_model", mg, 6'b111101);
        check("starve_stores_done", n_st, 6);
        check("starve_fetch_done", i_done, 1);

        // Store: byte store, d_rdata must keep the collision load result.
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h2004; bus.d_wdata = 32'hCAFEF00D; bus.d_type = DMT_BYTE;
        nrdy = 0;
        mem_auto(2);
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (bus.m_req) begin
                check("st_mwe", bus.m_we, 1);
                check("st_mtype", bus.m_type, DMT_BYTE);
                check("st_maddr", bus.m_addr, 32'h2004);
                check("st_mwdata", bus.m_wdata, 32'hCAFEF00D);
            end
            if (bus.d_ready) begin nrdy++; bus.d_req = 0; end
            mem_auto(2);
        end
        check("st_ready_pulses", nrdy, 1);
        check("st_drdata_kept", bus.d_rdata, 32'hA5001000);

        // Timeout: data load that is never acknowledged, then a late ack in IDLE.
        check("to_err_before", bus.err, 0);
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h4000; bus.d_type = DMT_WORD; bus.m_ack = 0;
        for (int t = 1; t <= 13; t++) begin
            tick();
            if (t <= 8) check("to_mreq_hold", bus.m_req, 1);
            if (t == 9) begin
                check("to_mreq_drop", bus.m_req, 0);
                check("to_dready", bus.d_ready, 1);
                check("to_drdata", bus.d_rdata, 32'hDEADBEEF);
                check("to_err_set", bus.err, 1);
                bus.d_req = 0;
            end
            if (t == 10) begin
                check("to_dready_once", bus.d_ready, 0);
                bus.m_ack = 1; bus.m_rdata = 32'h12345678;
            end
            if (t >= 11) begin
                bus.m_ack = 0;
                check("to_err_sticky", bus.err, 1);
                check("to_late_ack_ready", bus.d_ready, 0);
                check("to_late_ack_mreq", bus.m_req, 0);
            end
        end

        // Reset in the middle of a fetch grant, ack arriving afterwards.
        bus.i_req = 1; bus.i_addr = 32'h200;
        tick();
        check("rg_mreq_c1", bus.m_req, 1);
        tick();
        check("rg_mreq_c2", bus.m_req, 1);
        reset = 1;
        tick();
        check("rg_mreq_c3", bus.m_req, 0);
        check("rg_iready_c3", bus.i_ready, 0);
        check("rg_err_cleared", bus.err, 0);
        check("rg_state_idle", dut.state_q, ARB_IDLE);
        reset = 0; bus.m_ack = 1; bus.m_rdata = 32'h0BADF00D; bus.i_req = 0;
        for (int t = 4; t <= 8; t++) begin
            tick();
            bus.m_ack = 0;
            check("rg_iready_never", bus.i_ready, 0);
            check("rg_mreq_idle", bus.m_req, 0);
        end

        // Random traffic with random latencies, timeouts, stray acks and rare resets.
        mem_busy = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            reset = ($urandom_range(0, 699) == 0);
            drive_rand();
        end
        tick();
        reset = 0; bus.i_req = 0; bus.d_req = 0; bus.m_ack = 0;
        repeat (TIMEOUT + 4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
